// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data memory arbiter: FSM states, owner encoding, default latency.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_mem_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Which requester owns the current memory access.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  // Default memory read latency and the counter width that covers its legal range (1..15).
  localparam int DEF_MEM_LAT = 2;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick between the cpu and debug requesters.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arbiter2
  import data_mem_arbiter_pkg::*;
(
  input  logic   i_cpu_req,
  input  logic   i_dbg_req,
  input  owner_t i_last_grant,
  output owner_t o_grant
);

  // On contention hand the memory to the side that lost the previous contested pick;
  // otherwise the only requester wins. With no request the output is don't-care (cpu).
  always_comb begin
    o_grant = OWN_CPU;
    if (i_cpu_req && i_dbg_req) begin
      o_grant = (i_last_grant == OWN_CPU) ? OWN_DBG : OWN_CPU;
    end else if (i_dbg_req) begin
      o_grant = OWN_DBG;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one data memory between the pipeline MEM stage and the debug loader.
// Latency: request seen in IDLE at cycle t is acked at t+MEM_LAT+1; mem_en spans MEM_LAT cycles.
// Backpressure: one access in flight; the loser holds req, and stall_pipe freezes the cpu until its ack.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_pipe,
  output logic              wb_valid
);

  // ACCESS lasts MEM_LAT cycles: the counter starts at MEM_LAT-1 and read data is taken at zero.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  owner_t              r_last_grant;
  owner_t              r_owner;
  owner_t              w_grant;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_any_req;
  logic                w_both_req;
  logic                w_cnt_done;
  logic                w_win_we;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_wdata;

  assign w_any_req  = cpu_req | dbg_req;
  assign w_both_req = cpu_req & dbg_req;
  assign w_cnt_done = (r_cnt == '0);

  rr_arbiter2 u_rr (
    .i_cpu_req    (cpu_req),
    .i_dbg_req    (dbg_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Steer the winning requester's fields toward the request latches.
  always_comb begin
    w_win_we    = cpu_we;
    w_win_addr  = cpu_addr;
    w_win_wdata = cpu_wdata;
    if (w_grant == OWN_DBG) begin
      w_win_we    = dbg_we;
      w_win_addr  = dbg_addr;
      w_win_wdata = dbg_wdata;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request latches, latency counter, round-robin pointer and read-data capture.
  // The pointer only moves on a contested pick, so an uncontested access never
  // costs the other side its turn at the next collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_last_grant <= OWN_DBG;
      r_owner      <= OWN_CPU;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner <= w_grant;
            r_we    <= w_win_we;
            r_addr  <= w_win_addr;
            r_wdata <= w_win_wdata;
            r_cnt   <= CNT_LOAD;
            if (w_both_req) begin
              r_last_grant <= w_grant;
            end
          end
        end
        ACCESS: begin
          if (w_cnt_done) begin
            r_rdata <= mem_rdata;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic and state-decoded memory strobes and acks.
  always_comb begin
    w_next_state = r_state;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    cpu_ack      = 1'b0;
    dbg_ack      = 1'b0;
    wb_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = r_we;
        if (w_cnt_done) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        cpu_ack      = (r_owner == OWN_CPU);
        dbg_ack      = (r_owner == OWN_DBG);
        wb_valid     = (r_owner == OWN_CPU) & ~r_we;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Address and write data come only from the latches, so requester inputs
  // moving during ACCESS cannot disturb the memory.
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign cpu_rdata  = r_rdata;
  assign dbg_rdata  = r_rdata;
  assign stall_pipe = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Latency: n/a.
// Backpressure: requesters obey hold-until-ack, drop-one-cycle-after-ack.
module tb_data_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_ack, dbg_ack, mem_en, mem_we, stall_pipe, wb_valid;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        b_cpu_req, b_cpu_we, b_dbg_req, b_dbg_we;
  logic [31:0] b_cpu_addr, b_cpu_wdata, b_dbg_addr, b_dbg_wdata;
  logic        b_cpu_ack, b_dbg_ack, b_mem_en, b_mem_we, b_stall_pipe, b_wb_valid;
  logic [31:0] b_cpu_rdata, b_dbg_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_pipe(stall_pipe), .wb_valid(wb_valid)
  );

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_lat1 (
    .clk(clk), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .dbg_req(b_dbg_req), .dbg_we(b_dbg_we), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata),
    .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .stall_pipe(b_stall_pipe), .wb_valid(b_wb_valid)
  );

  // Power-up memory contents, indexed by word address bits [9:2].
  function automatic logic [31:0] init_word(input logic [7:0] idx);
    if (idx == 8'h10) return 32'hDEADBEEF;
    if (idx == 8'h40) return 32'hCAFEF00D;
    return {idx, ~idx, idx ^ 8'h5A, 8'h3C};
  endfunction

  // Memory device for the MEM_LAT=2 instance: read data appears two edges after the
  // first enabled cycle and is zero otherwise, so early or late capture is visible.
  logic [31:0] dev_mem [256];
  bit          dev_wr  [256];
  logic [31:0] rd_pipe = '0;

  function automatic logic [31:0] dev_rd(input logic [7:0] idx);
    return dev_wr[idx] ? dev_mem[idx] : init_word(idx);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      dev_mem[mem_addr[9:2]] <= mem_wdata;
      dev_wr[mem_addr[9:2]]  <= 1'b1;
    end
    rd_pipe <= mem_en ? dev_rd(mem_addr[9:2]) : '0;
  end
  assign mem_rdata = rd_pipe;

  // Single-cycle device for the MEM_LAT=1 instance (read-only).
  assign b_mem_rdata = b_mem_en ? init_word(b_mem_addr[9:2]) : '0;

  // Transaction-level reference: each grant at cycle g occupies g+1..g+LAT on the
  // memory, acks at g+LAT+1, and the arbiter accepts again at g+LAT+2.
  int          cyc       = 0;
  int          m_free    = 0;
  int          m_gnt     = -100;
  int          m_ack     = -1;
  int          m_rst_chk = -1;
  bit          m_dbg     = 1'b0;
  bit          m_last_dbg = 1'b1;
  logic        m_we      = 1'b0;
  logic [31:0] m_addr    = '0;
  logic [31:0] m_wdata   = '0;
  logic [31:0] m_rexp    = '0;
  logic [31:0] ref_mem [256];
  bit          prev_cack = 1'b0;
  bit          prev_dack = 1'b0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Compare the current cycle against the model mid-cycle, then advance the model
  // and move to just after the next rising edge, where inputs for the new cycle go.
  task automatic tick();
    logic       in_acc, is_ack, e_cack, e_dack;
    logic [7:0] idx;
    @(negedge clk);
    in_acc = (cyc > m_gnt) && (cyc <= m_gnt + LAT);
    is_ack = (cyc == m_ack);
    e_cack = is_ack && !m_dbg;
    e_dack = is_ack && m_dbg;
    chk1("cpu_ack", cpu_ack, e_cack);
    chk1("dbg_ack", dbg_ack, e_dack);
    chk1("mem_en", mem_en, in_acc);
    chk1("mem_we", mem_we, in_acc && m_we);
    chk1("wb_valid", wb_valid, e_cack && !m_we);
    chk1("stall_pipe", stall_pipe, cpu_req && !e_cack);
    if (in_acc) begin
      chk32("mem_addr", mem_addr, m_addr);
      if (m_we) chk32("mem_wdata", mem_wdata, m_wdata);
    end
    if (e_cack && !m_we) chk32("cpu_rdata", cpu_rdata, m_rexp);
    if (e_dack && !m_we) chk32("dbg_rdata", dbg_rdata, m_rexp);
    if (cyc == m_rst_chk) begin
      chk32("rst_cpu_rdata", cpu_rdata, 32'h0);
      chk32("rst_dbg_rdata", dbg_rdata, 32'h0);
      chk32("rst_mem_addr", mem_addr, 32'h0);
      chk32("rst_mem_wdata", mem_wdata, 32'h0);
    end
    prev_cack = e_cack;
    prev_dack = e_dack;
    if (reset) begin
      m_free     = cyc + 1;
      m_gnt      = -100;
      m_ack      = -1;
      m_last_dbg = 1'b1;
      m_rst_chk  = cyc + 1;
    end else if (cyc >= m_free && (cpu_req || dbg_req)) begin
      if (cpu_req && dbg_req) begin
        m_dbg      = !m_last_dbg;
        m_last_dbg = m_dbg;
      end else begin
        m_dbg = dbg_req;
      end
      m_gnt   = cyc;
      m_ack   = cyc + LAT + 1;
      m_free  = cyc + LAT + 2;
      m_we    = m_dbg ? dbg_we : cpu_we;
      m_addr  = m_dbg ? dbg_addr : cpu_addr;
      m_wdata = m_dbg ? dbg_wdata : cpu_wdata;
      idx     = m_addr[9:2];
      m_rexp  = ref_mem[idx];
      if (m_we) ref_mem[idx] = m_wdata;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = '0; b_cpu_wdata = '0;
    b_dbg_req = 1'b0; b_dbg_we = 1'b0; b_dbg_addr = '0; b_dbg_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    @(posedge clk);
    #1;
    tick();
    tick();
    reset = 1'b0;
    chk1("rst_b_mem_en", b_mem_en, 1'b0);
    chk1("rst_b_cpu_ack", b_cpu_ack, 1'b0);
    tick();

    // cpu load of 0x40 returning 0xDEADBEEF.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    tick();
    chk1("s1_mem_en_t1", mem_en, 1'b1);
    tick();
    chk1("s1_mem_en_t2", mem_en, 1'b1);
    tick();
    chk1("s1_cpu_ack_t3", cpu_ack, 1'b1);
    chk1("s1_wb_valid_t3", wb_valid, 1'b1);
    chk32("s1_cpu_rdata_t3", cpu_rdata, 32'hDEADBEEF);
    tick();
    cpu_req = 1'b0;
    tick();

    // Collision after reset: cpu first, dbg next; a repeat collision goes to dbg.
    cpu_req = 1'b1; cpu_addr = 32'h44; cpu_we = 1'b0;
    dbg_req = 1'b1; dbg_addr = 32'h48; dbg_we = 1'b0;
    tick(); tick(); tick();
    chk1("s2_cpu_ack_t3", cpu_ack, 1'b1);
    chk1("s2_dbg_ack_t3", dbg_ack, 1'b0);
    tick();
    cpu_req = 1'b0;
    tick();
    chk32("s2_dbg_addr_t5", mem_addr, 32'h48);
    tick(); tick();
    chk1("s2_dbg_ack_t7", dbg_ack, 1'b1);
    chk32("s2_dbg_rdata_t7", dbg_rdata, init_word(8'h12));
    tick();
    dbg_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_addr = 32'h50;
    dbg_req = 1'b1; dbg_addr = 32'h54;
    tick();
    chk32("s2b_winner_addr", mem_addr, 32'h54);
    tick(); tick();
    chk1("s2b_dbg_ack_t3", dbg_ack, 1'b1);
    chk1("s2b_cpu_ack_t3", cpu_ack, 1'b0);
    tick();
    dbg_req = 1'b0;
    tick(); tick(); tick();
    chk1("s2b_cpu_ack_t7", cpu_ack, 1'b1);
    tick();
    cpu_req = 1'b0;
    tick();

    // dbg store of 0x12345678 to 0x80, then a cpu load reads it back.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h80; dbg_wdata = 32'h12345678;
    tick();
    chk1("s3_mem_we_t1", mem_we, 1'b1);
    chk32("s3_mem_addr_t1", mem_addr, 32'h80);
    chk32("s3_mem_wdata_t1", mem_wdata, 32'h12345678);
    tick();
    chk1("s3_mem_we_t2", mem_we, 1'b1);
    tick();
    chk1("s3_dbg_ack_t3", dbg_ack, 1'b1);
    chk1("s3_wb_valid_t3", wb_valid, 1'b0);
    tick();
    dbg_req = 1'b0; dbg_we = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_addr = 32'h80;
    tick(); tick(); tick();
    chk32("s3_readback", cpu_rdata, 32'h12345678);
    tick();
    cpu_req = 1'b0;
    tick();

    // Reset in the second ACCESS cycle aborts; a fresh load then completes.
    cpu_req = 1'b1; cpu_addr = 32'h44;
    tick(); tick();
    reset = 1'b1; cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    chk1("s4_mem_en_after_rst", mem_en, 1'b0);
    chk1("s4_cpu_ack_after_rst", cpu_ack, 1'b0);
    chk1("s4_wb_after_rst", wb_valid, 1'b0);
    tick(); tick();
    cpu_req = 1'b1; cpu_addr = 32'h40;
    tick(); tick(); tick();
    chk1("s4_cpu_ack_new", cpu_ack, 1'b1);
    chk32("s4_cpu_rdata_new", cpu_rdata, 32'hDEADBEEF);
    tick();
    cpu_req = 1'b0;
    tick();

    // MEM_LAT=1 instance: cpu_addr moved during ACCESS must not reach the memory.
    b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 32'h100;
    tick();
    chk1("s5_mem_en_t1", b_mem_en, 1'b1);
    chk32("s5_mem_addr_t1", b_mem_addr, 32'h100);
    chk1("s5_cpu_ack_t1", b_cpu_ack, 1'b0);
    chk1("s5_stall_t1", b_stall_pipe, 1'b1);
    b_cpu_addr = 32'h200;
    tick();
    chk1("s5_cpu_ack_t2", b_cpu_ack, 1'b1);
    chk1("s5_wb_valid_t2", b_wb_valid, 1'b1);
    chk32("s5_cpu_rdata_t2", b_cpu_rdata, 32'hCAFEF00D);
    chk32("s5_mem_addr_t2", b_mem_addr, 32'h100);
    b_cpu_req = 1'b0;
    tick();
    chk1("s5_cpu_ack_t3", b_cpu_ack, 1'b0);
    chk1("s5_mem_en_t3", b_mem_en, 1'b0);

    // Random traffic from both requesters, with input scrambling during ACCESS.
    for (int n = 0; n < 3000; n++) begin
      if (prev_cack) begin
        cpu_req = 1'b0;
      end else if (!cpu_req) begin
        if ($urandom_range(0, 2) == 0) begin
          cpu_req   = 1'b1;
          cpu_we    = 1'($urandom_range(0, 1));
          cpu_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
          cpu_wdata = $urandom;
        end
      end else if (!m_dbg && cyc > m_gnt && cyc <= m_gnt + LAT && $urandom_range(0, 1) == 1) begin
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
      end
      if (prev_dack) begin
        dbg_req = 1'b0;
      end else if (!dbg_req) begin
        if ($urandom_range(0, 2) == 0) begin
          dbg_req   = 1'b1;
          dbg_we    = 1'($urandom_range(0, 1));
          dbg_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
          dbg_wdata = $urandom;
        end
      end else if (m_dbg && cyc > m_gnt && cyc <= m_gnt + LAT && $urandom_range(0, 1) == 1) begin
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = $urandom;
        dbg_wdata = $urandom;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
